// File: rtl/quick_cpu_pkg.sv
// rtl/quick_cpu_pkg.sv - shared opcodes, state type and width default for the quick CPU sequencer
package quick_cpu_pkg;

    localparam int PC_W_DEFAULT = 8;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_LDI  = 8'h10;
    localparam logic [7:0] OP_ADD  = 8'h20;
    localparam logic [7:0] OP_JMP  = 8'h30;
    localparam logic [7:0] OP_JZ   = 8'h31;
    localparam logic [7:0] OP_HALT = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH_OP  = 3'd1,
        ST_DECODE    = 3'd2,
        ST_FETCH_IMM = 3'd3,
        ST_EXEC      = 3'd4,
        ST_HALT      = 3'd5
    } seq_state_t;

endpackage

// File: rtl/quick_cpu_decode.sv
// rtl/quick_cpu_decode.sv - combinational opcode classifier for the quick CPU
module quick_cpu_decode
    import quick_cpu_pkg::*;
(
    input  logic [7:0] ir,
    output logic       needs_imm,
    output logic       is_ldi,
    output logic       is_add,
    output logic       is_jmp,
    output logic       is_jz,
    output logic       is_halt,
    output logic       illegal
);

    logic is_nop;

    // LDI and ADD use bit 0 as the destination register select
    assign is_nop    = (ir == OP_NOP);
    assign is_ldi    = ({ir[7:1], 1'b0} == OP_LDI);
    assign is_add    = ({ir[7:1], 1'b0} == OP_ADD);
    assign is_jmp    = (ir == OP_JMP);
    assign is_jz     = (ir == OP_JZ);
    assign is_halt   = (ir == OP_HALT);
    assign needs_imm = is_ldi | is_jmp | is_jz;
    assign illegal   = ~(is_nop | is_ldi | is_add | is_jmp | is_jz | is_halt);

endmodule

// File: rtl/quick_cpu_sequencer.sv
// rtl/quick_cpu_sequencer.sv - fetch/decode/execute controller driving the quick CPU datapath
module quick_cpu_sequencer
    import quick_cpu_pkg::*;
#(
    parameter int PC_W = PC_W_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            step_mode,
    output logic            mem_req,
    output logic [PC_W-1:0] mem_addr,
    input  logic            mem_ack,
    input  logic [7:0]      mem_rdata,
    input  logic            zero_flag,
    output logic            rf_we,
    output logic            rf_sel,
    output logic            rf_src,
    output logic [7:0]      imm_out,
    output logic            busy,
    output logic            halted,
    output logic            err
);

    seq_state_t      state;
    logic [PC_W-1:0] pc;
    logic [7:0]      ir;
    logic [7:0]      imm;

    logic needs_imm, is_ldi, is_add, is_jmp, is_jz, is_halt, illegal;

    quick_cpu_decode u_decode (
        .ir        (ir),
        .needs_imm (needs_imm),
        .is_ldi    (is_ldi),
        .is_add    (is_add),
        .is_jmp    (is_jmp),
        .is_jz     (is_jz),
        .is_halt   (is_halt),
        .illegal   (illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            pc    <= '0;
            ir    <= 8'h00;
            imm   <= 8'h00;
            err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) state <= ST_FETCH_OP;
                end
                ST_HALT: begin
                    if (start) begin
                        err   <= 1'b0;
                        pc    <= '0;
                        state <= ST_FETCH_OP;
                    end
                end
                ST_FETCH_OP: begin
                    if (mem_ack) begin
                        ir    <= mem_rdata;
                        pc    <= pc + PC_W'(1);
                        state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (illegal) begin
                        err   <= 1'b1;
                        state <= ST_HALT;
                    end else if (is_halt) begin
                        state <= ST_HALT;
                    end else if (needs_imm) begin
                        state <= ST_FETCH_IMM;
                    end else begin
                        state <= ST_EXEC;
                    end
                end
                ST_FETCH_IMM: begin
                    if (mem_ack) begin
                        imm   <= mem_rdata;
                        pc    <= pc + PC_W'(1);
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // zero_flag reflects A before this cycle's register write lands
                    if (is_jmp || (is_jz && zero_flag)) pc <= PC_W'(imm);
                    state <= step_mode ? ST_IDLE : ST_FETCH_OP;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Decoded straight from state so an async reset drops the request at once
    assign mem_req  = (state == ST_FETCH_OP) || (state == ST_FETCH_IMM);
    assign mem_addr = pc;
    assign rf_we    = (state == ST_EXEC) && (is_ldi || is_add);
    assign rf_sel   = rf_we & ir[0];
    assign rf_src   = rf_we & is_add;
    assign imm_out  = imm;
    assign busy     = (state != ST_IDLE) && (state != ST_HALT);
    assign halted   = (state == ST_HALT);

endmodule

// File: tb/tb_quick_cpu_sequencer.sv
// tb/tb_quick_cpu_sequencer.sv - self-checking bench for quick_cpu_sequencer
module tb_quick_cpu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       step_mode = 1'b0;
    logic       mem_ack = 1'b0;
    logic [7:0] mem_rdata = 8'h00;
    logic       zero_flag = 1'b1;
    logic       mem_req, rf_we, rf_sel, rf_src, busy, halted, err;
    logic [7:0] mem_addr, imm_out;

    quick_cpu_sequencer #(.PC_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .step_mode (step_mode),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .zero_flag (zero_flag),
        .rf_we     (rf_we),
        .rf_sel    (rf_sel),
        .rf_src    (rf_src),
        .imm_out   (imm_out),
        .busy      (busy),
        .halted    (halted),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       sel;
        logic       src;
        logic [7:0] imm;
    } wr_t;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] mem [256];
    logic [7:0] exp_fetch [$];
    wr_t        exp_wr [$];
    int         exp_busy;
    logic [7:0] exp_pc;
    logic       exp_halt, exp_err;
    logic [7:0] dp_a = 8'h00;
    logic [7:0] dp_b = 8'h00;
    logic [7:0] cur_pc = 8'h00;
    logic       in_halt = 1'b0;
    int         fw;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic fill_mem(input logic [7:0] v);
        for (int i = 0; i < 256; i++) mem[i] = v;
    endtask

    // Instruction-level interpreter: what the program should fetch, write and cost
    task automatic model(input logic [7:0] pc0, input int max_instr);
        logic [7:0] pc, a, b, op, imm;
        pc = pc0; a = dp_a; b = dp_b; imm = 8'h00;
        exp_fetch.delete(); exp_wr.delete();
        exp_busy = 0; exp_halt = 1'b0; exp_err = 1'b0;
        for (int n = 0; n < max_instr && !exp_halt; n++) begin
            op = mem[pc];
            exp_fetch.push_back(pc);
            pc = pc + 8'd1;
            if (op == 8'h10 || op == 8'h11 || op == 8'h30 || op == 8'h31) begin
                imm = mem[pc];
                exp_fetch.push_back(pc);
                pc = pc + 8'd1;
                exp_busy += 4;
            end
            case (op)
                8'h00: exp_busy += 3;
                8'h10, 8'h11: begin
                    exp_wr.push_back({op[0], 1'b0, imm});
                    if (op[0]) b = imm; else a = imm;
                end
                8'h20, 8'h21: begin
                    exp_busy += 3;
                    exp_wr.push_back({op[0], 1'b1, 8'h00});
                    if (op[0]) b = a + b; else a = a + b;
                end
                8'h30: pc = imm;
                8'h31: if (a == 8'h00) pc = imm;
                8'hFF: begin exp_busy += 2; exp_halt = 1'b1; end
                default: begin exp_busy += 2; exp_halt = 1'b1; exp_err = 1'b1; end
            endcase
        end
        exp_pc = pc;
    endtask

    // Drives one start pulse and services memory until the sequencer goes quiet
    task automatic run(input int wmode, input string tag, output int first_we);
        int         cyc, waits, wl;
        bit         active;
        logic [7:0] raddr, val;
        wr_t        w;
        cyc = 0; waits = 0; wl = 0; active = 0; raddr = 8'h00; first_we = -1;
        zero_flag = (dp_a == 8'h00);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check({tag, "_err_first"}, 32'(err), 32'(0));
        while (busy === 1'b1 && cyc < 2000) begin
            cyc++;
            if (rf_we === 1'b1) begin
                if (first_we < 0) first_we = cyc;
                if (exp_wr.size() == 0) begin
                    check({tag, "_extra_we"}, 32'(1), 32'(0));
                end else begin
                    w = exp_wr.pop_front();
                    check({tag, "_rf_sel"}, 32'(rf_sel), 32'(w.sel));
                    check({tag, "_rf_src"}, 32'(rf_src), 32'(w.src));
                    if (!w.src) check({tag, "_imm_out"}, 32'(imm_out), 32'(w.imm));
                end
                val = rf_src ? dp_a + dp_b : imm_out;
                if (rf_sel) dp_b = val; else dp_a = val;
            end else begin
                check({tag, "_idle_sel_src"}, 32'({rf_sel, rf_src}), 32'(0));
            end
            if (mem_req === 1'b1) begin
                if (!active) begin
                    active = 1;
                    raddr = mem_addr;
                    wl = (wmode < 0) ? int'($urandom_range(0, 3)) : wmode;
                    if (exp_fetch.size() == 0) check({tag, "_extra_fetch"}, 32'(1), 32'(0));
                    else check({tag, "_fetch_addr"}, 32'(mem_addr), 32'(exp_fetch.pop_front()));
                end else begin
                    check({tag, "_addr_stable"}, 32'(mem_addr), 32'(raddr));
                end
                if (wl == 0) begin
                    mem_ack = 1'b1;
                    mem_rdata = mem[mem_addr];
                    active = 0;
                end else begin
                    wl--;
                    waits++;
                    mem_ack = 1'b0;
                    mem_rdata = 8'($urandom);
                end
            end else begin
                mem_ack = ($urandom_range(0, 3) == 0);
                mem_rdata = 8'($urandom);
            end
            zero_flag = (dp_a == 8'h00);
            @(negedge clk);
        end
        mem_ack = 1'b0;
        check({tag, "_busy_cycles"}, 32'(cyc), 32'(exp_busy + waits));
        check({tag, "_halted"}, 32'(halted), 32'(exp_halt));
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        check({tag, "_pc"}, 32'(mem_addr), 32'(exp_pc));
        check({tag, "_fetch_left"}, 32'(exp_fetch.size()), 32'(0));
        check({tag, "_we_left"}, 32'(exp_wr.size()), 32'(0));
    endtask

    task automatic do_run(input int wmode, input string tag, output int first_we);
        step_mode = 1'b0;
        model(in_halt ? 8'h00 : cur_pc, 300);
        run(wmode, tag, first_we);
        cur_pc = exp_pc;
        in_halt = exp_halt;
    endtask

    task automatic do_step(input int wmode, input string tag);
        int f;
        step_mode = 1'b1;
        model(in_halt ? 8'h00 : cur_pc, 1);
        run(wmode, tag, f);
        cur_pc = exp_pc;
        in_halt = exp_halt;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check({tag, "_quiet_busy"}, 32'(busy), 32'(0));
            check({tag, "_quiet_req"}, 32'(mem_req), 32'(0));
        end
    endtask

    task automatic gen_random();
        int p;
        for (int attempt = 0; attempt < 20; attempt++) begin
            fill_mem(8'hFF);
            p = 0;
            while (p < 48) begin
                case ($urandom_range(0, 9))
                    0, 8: begin mem[p] = 8'h00; p += 1; end
                    1, 2: begin
                        mem[p] = 8'h10 | 8'($urandom_range(0, 1));
                        mem[p + 1] = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
                        p += 2;
                    end
                    3, 4: begin mem[p] = 8'h20 | 8'($urandom_range(0, 1)); p += 1; end
                    5, 6: begin mem[p] = 8'h31; mem[p + 1] = 8'(p + 2 + int'($urandom_range(0, 6))); p += 2; end
                    7: begin mem[p] = 8'h30; mem[p + 1] = 8'(p + 2 + int'($urandom_range(0, 4))); p += 2; end
                    default: begin
                        mem[p] = ($urandom_range(0, 4) == 0) ? 8'h55 : 8'h21;
                        p += 1;
                    end
                endcase
            end
            model(in_halt ? 8'h00 : cur_pc, 300);
            if (exp_halt) break;
        end
        if (!exp_halt) begin
            fill_mem(8'hFF);
        end
    endtask

    initial begin
        fill_mem(8'hFF);
        repeat (3) @(negedge clk);
        check("rst_mem_req", 32'(mem_req), 32'(0));
        check("rst_rf_we", 32'(rf_we), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_halted", 32'(halted), 32'(0));
        check("rst_err", 32'(err), 32'(0));
        check("rst_pc", 32'(mem_addr), 32'(0));
        check("rst_imm", 32'(imm_out), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_release_busy", 32'(busy), 32'(0));

        mem[0] = 8'h10; mem[1] = 8'h05; mem[2] = 8'hFF;
        do_run(0, "ldi_halt", fw);
        check("ldi_we_cycle", 32'(fw), 32'(4));
        check("ldi_imm_value", 32'(imm_out), 32'h05);
        check("ldi_pc3", 32'(mem_addr), 32'h03);

        fill_mem(8'hFF);
        mem[0] = 8'h00; mem[1] = 8'h21; mem[2] = 8'hFF;
        do_run(2, "nop_add_wait2", fw);
        check("add_we_cycle", 32'(fw), 32'(10));

        fill_mem(8'hFF);
        mem[0] = 8'h10; mem[1] = 8'h00; mem[2] = 8'h31; mem[3] = 8'h40;
        do_run(0, "jz_taken", fw);
        check("jz_taken_pc", 32'(mem_addr), 32'h41);

        mem[1] = 8'h03; mem[4] = 8'hFF;
        do_run(1, "jz_not_taken", fw);
        check("jz_not_taken_pc", 32'(mem_addr), 32'h05);

        fill_mem(8'hFF);
        mem[0] = 8'h30; mem[1] = 8'hFF;
        do_step(0, "jmp_ff");
        check("jmp_ff_pc", 32'(mem_addr), 32'hFF);
        mem[0] = 8'h07; mem[8'hFF] = 8'h10;
        do_run(0, "pc_wrap", fw);
        check("wrap_imm", 32'(imm_out), 32'h07);

        fill_mem(8'hFF);
        mem[0] = 8'h55;
        do_run(0, "illegal", fw);
        check("illegal_err", 32'(err), 32'(1));
        mem[0] = 8'h00; mem[1] = 8'hFF;
        do_run(0, "after_illegal", fw);
        check("after_illegal_err", 32'(err), 32'(0));

        fill_mem(8'hFF);
        mem[0] = 8'h10; mem[1] = 8'h07; mem[2] = 8'h21; mem[3] = 8'hFF;
        do_step(0, "step_ldi");
        do_step(1, "step_add");
        do_run(0, "step_finish", fw);

        for (int r = 0; r < 8; r++) begin
            gen_random();
            do_run(-1, "random", fw);
        end

        fill_mem(8'hFF);
        mem[0] = 8'h00;
        step_mode = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; mem_ack = 1'b0;
        check("pre_rst_req", 32'(mem_req), 32'(1));
        @(negedge clk);
        rst_n = 1'b0; mem_ack = 1'b1;
        #1;
        check("rst_drop_req", 32'(mem_req), 32'(0));
        check("rst_drop_busy", 32'(busy), 32'(0));
        @(negedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'(0));
        check("post_rst_req", 32'(mem_req), 32'(0));
        check("post_rst_pc", 32'(mem_addr), 32'(0));
        check("post_rst_err", 32'(err), 32'(0));
        mem_ack = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
